// File: rtl/data_mem_bridge.sv
// -----------------------------------------------------------------------------
// data_mem_bridge
//
// Serializes DATA_MEM_CHANNELS independent valid/ready read/write request
// channels onto a single-port synchronous SRAM that has a 1-cycle read
// latency. Channels are arbitrated round-robin. Only one access is in flight
// at a time. Each completed request gets a one-cycle ready pulse.
//
// Ports
//   clk, rst_n                  clock; synchronous active-low reset
//   data_mem_read_valid/addr    per-channel read request
//   data_mem_read_ready/data    per-channel read completion pulse and data
//   data_mem_write_valid/addr/data  per-channel write request
//   data_mem_write_ready        per-channel write completion pulse
//   sram_en/we/addr/wdata       SRAM command (registered)
//   sram_rdata                  SRAM read data, valid the cycle after a read
//   busy                        high whenever the FSM is not idle
//
// States
//   state     | meaning
//   S_IDLE    | arbitrate among eligible channels; latch the winner
//   S_ISSUE   | SRAM command is on the bus (sram_en=1)
//   S_CAPTURE | read data is returned by the SRAM; capture it
//   S_ACK     | ready pulse to the granted channel; arm its cooldown
// -----------------------------------------------------------------------------
module data_mem_bridge #(
  parameter int DATA_WIDTH        = 8,
  parameter int DATA_ADDR_WIDTH   = 8,
  parameter int DATA_MEM_CHANNELS = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DATA_MEM_CHANNELS-1:0] data_mem_read_valid,
  input  logic [DATA_ADDR_WIDTH-1:0]   data_mem_read_addr   [DATA_MEM_CHANNELS],
  output logic [DATA_MEM_CHANNELS-1:0] data_mem_read_ready,
  output logic [DATA_WIDTH-1:0]        data_mem_read_data   [DATA_MEM_CHANNELS],
  input  logic [DATA_MEM_CHANNELS-1:0] data_mem_write_valid,
  input  logic [DATA_ADDR_WIDTH-1:0]   data_mem_write_addr  [DATA_MEM_CHANNELS],
  input  logic [DATA_WIDTH-1:0]        data_mem_write_data  [DATA_MEM_CHANNELS],
  output logic [DATA_MEM_CHANNELS-1:0] data_mem_write_ready,
  output logic                         sram_en,
  output logic                         sram_we,
  output logic [DATA_ADDR_WIDTH-1:0]   sram_addr,
  output logic [DATA_WIDTH-1:0]        sram_wdata,
  input  logic [DATA_WIDTH-1:0]        sram_rdata,
  output logic                         busy
);

  localparam int CH_W = (DATA_MEM_CHANNELS > 1) ? $clog2(DATA_MEM_CHANNELS) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(DATA_MEM_CHANNELS - 1);
  localparam logic [CH_W:0]   NUM_CH  = (CH_W+1)'(DATA_MEM_CHANNELS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_ACK     = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [CH_W-1:0]              grant_q, grant_d;
  logic [CH_W-1:0]              rr_ptr_q, rr_ptr_d;
  logic                         op_we_q, op_we_d;
  logic [DATA_MEM_CHANNELS-1:0] cooldown_q, cooldown_d;

  logic                         sram_en_d, sram_we_d;
  logic [DATA_ADDR_WIDTH-1:0]   sram_addr_d;
  logic [DATA_WIDTH-1:0]        sram_wdata_d;
  logic [DATA_MEM_CHANNELS-1:0] read_ready_d, write_ready_d;
  logic                         busy_d;
  logic                         capture_en;

  logic [DATA_MEM_CHANNELS-1:0] eligible;
  logic                         pick_found;
  logic [CH_W-1:0]              pick_idx;
  logic [CH_W:0]                cand;

  // Round-robin pick: first eligible channel at or after rr_ptr, wrapping.
  // cand is one bit wider than a channel index so rr_ptr + i cannot overflow
  // before the modulo correction.
  always_comb begin
    eligible   = (data_mem_read_valid | data_mem_write_valid) & ~cooldown_q;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < DATA_MEM_CHANNELS; i++) begin
      cand = {1'b0, rr_ptr_q} + (CH_W+1)'(i);
      if (cand >= NUM_CH) begin
        cand = cand - NUM_CH;
      end
      if (!pick_found && eligible[cand[CH_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[CH_W-1:0];
      end
    end
  end

  // Next-state and next-output logic. Outputs are registered, so the SRAM
  // command is computed on the IDLE->ISSUE transition and the ready pulse on
  // the CAPTURE->ACK transition.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    op_we_d       = op_we_q;
    cooldown_d    = cooldown_q;
    sram_en_d     = 1'b0;
    sram_we_d     = 1'b0;
    sram_addr_d   = '0;
    sram_wdata_d  = '0;
    read_ready_d  = '0;
    write_ready_d = '0;
    capture_en    = 1'b0;

    case (state_q)
      S_IDLE: begin
        cooldown_d = '0;
        if (pick_found) begin
          state_d   = S_ISSUE;
          grant_d   = pick_idx;
          // A write beats a read on the same channel; the read stays
          // pending and wins a later grant.
          op_we_d   = data_mem_write_valid[pick_idx];
          rr_ptr_d  = (pick_idx == LAST_CH) ? '0 : pick_idx + CH_W'(1);
          sram_en_d = 1'b1;
          sram_we_d = op_we_d;
          if (op_we_d) begin
            sram_addr_d  = data_mem_write_addr[pick_idx];
            sram_wdata_d = data_mem_write_data[pick_idx];
          end else begin
            sram_addr_d  = data_mem_read_addr[pick_idx];
          end
        end
      end
      S_ISSUE: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        state_d    = S_ACK;
        capture_en = !op_we_q;
        if (op_we_q) begin
          write_ready_d[grant_q] = 1'b1;
        end else begin
          read_ready_d[grant_q] = 1'b1;
        end
      end
      S_ACK: begin
        state_d             = S_IDLE;
        // Mask the just-served channel for one idle cycle so a requester
        // still holding valid right after its pulse is not granted twice.
        cooldown_d          = '0;
        cooldown_d[grant_q] = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_q              <= '0;
      rr_ptr_q             <= '0;
      op_we_q              <= 1'b0;
      cooldown_q           <= '0;
      sram_en              <= 1'b0;
      sram_we              <= 1'b0;
      sram_addr            <= '0;
      sram_wdata           <= '0;
      data_mem_read_ready  <= '0;
      data_mem_write_ready <= '0;
      busy                 <= 1'b0;
      for (int c = 0; c < DATA_MEM_CHANNELS; c++) begin
        data_mem_read_data[c] <= '0;
      end
    end else begin
      grant_q              <= grant_d;
      rr_ptr_q             <= rr_ptr_d;
      op_we_q              <= op_we_d;
      cooldown_q           <= cooldown_d;
      sram_en              <= sram_en_d;
      sram_we              <= sram_we_d;
      sram_addr            <= sram_addr_d;
      sram_wdata           <= sram_wdata_d;
      data_mem_read_ready  <= read_ready_d;
      data_mem_write_ready <= write_ready_d;
      busy                 <= busy_d;
      // Only the granted channel's data register ever changes; the others
      // keep their last captured word.
      if (capture_en) begin
        data_mem_read_data[grant_q] <= sram_rdata;
      end
    end
  end

endmodule

// File: doc/data_mem_bridge.md
Name: data_mem_bridge

Overview:
- Sits directly downstream of the gpu data-memory channel interface.
- Accepts DATA_MEM_CHANNELS independent read/write request channels using the gpu valid/ready protocol and serializes them onto one single-port synchronous SRAM with 1-cycle read latency.
- Arbitrates round-robin across channels, holds one access in flight at a time, and returns a one-cycle ready pulse per completed request.

Parameters:
- DATA_WIDTH, 8, data word width.
- DATA_ADDR_WIDTH, 8, address width; the SRAM holds 2**DATA_ADDR_WIDTH words.
- DATA_MEM_CHANNELS, 4, number of request channels (>=1).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- data_mem_read_valid  input  [DATA_MEM_CHANNELS-1:0]  per-channel read request.
- data_mem_read_addr  input  [DATA_ADDR_WIDTH-1:0] x DATA_MEM_CHANNELS  read address.
- data_mem_read_ready  output  [DATA_MEM_CHANNELS-1:0]  one-cycle read completion pulse.
- data_mem_read_data  output  [DATA_WIDTH-1:0] x DATA_MEM_CHANNELS  read data; valid when ready is high.
- data_mem_write_valid  input  [DATA_MEM_CHANNELS-1:0]  per-channel write request.
- data_mem_write_addr  input  [DATA_ADDR_WIDTH-1:0] x DATA_MEM_CHANNELS  write address.
- data_mem_write_data  input  [DATA_WIDTH-1:0] x DATA_MEM_CHANNELS  write data.
- data_mem_write_ready  output  [DATA_MEM_CHANNELS-1:0]  one-cycle write completion pulse.
- sram_en  output  1  SRAM access enable.
- sram_we  output  1  SRAM write enable (1 = write, 0 = read).
- sram_addr  output  DATA_ADDR_WIDTH  SRAM address.
- sram_wdata  output  DATA_WIDTH  SRAM write data.
- sram_rdata  input  DATA_WIDTH  SRAM read data; valid the cycle after an en=1, we=0 cycle.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous, active-low, on rst_n. While rst_n=0 at a rising edge:
  - FSM -> IDLE, rr_ptr -> 0, cooldown mask -> 0.
  - All outputs -> 0, including every read_data entry.
- Reset mid-operation:
  - In-flight request is dropped with no ready pulse.
  - A write whose ISSUE cycle already completed stays committed in the SRAM.
- Requester contract:
  - Holds valid, addr and data stable until it sees its ready pulse.
  - May keep valid high for up to 1 cycle after the pulse.
- All outputs are registered.
- FSM: IDLE -> ISSUE -> CAPTURE -> ACK -> IDLE.
- IDLE:
  - Eligible channel = (read_valid | write_valid) & ~cooldown.
  - If any channel is eligible, grant the first one at or after rr_ptr, modulo DATA_MEM_CHANNELS.
  - Latch the granted channel, op, addr and wdata.
  - Within a granted channel, write beats read when both are valid; the read is served on a later grant.
  - rr_ptr <= grant+1 (wraps to 0 past the last channel).
  - Clear cooldown. Go to ISSUE.
  - If nothing is eligible, clear cooldown and stay in IDLE.
- ISSUE: sram_en=1, sram_we=op, sram_addr/sram_wdata = latched values. Go to CAPTURE.
- CAPTURE:
  - sram_en=0.
  - For a read, capture sram_rdata into data_mem_read_data[grant].
  - Go to ACK.
- ACK:
  - Assert data_mem_read_ready[grant] or data_mem_write_ready[grant] for exactly this cycle.
  - Set cooldown[grant]=1 for the following IDLE cycle. Go to IDLE.
- Latency: valid sampled at edge k in IDLE -> sram_en high in cycle k+1 -> ready high in cycle k+3.
- Throughput: one access per 4 cycles. With N channels continuously requesting, each channel is served once every N grants.
- read_data[c] holds its last captured value until channel c's next read completes. Other channels' data is never disturbed.
- Never more than one ready bit high across both ready vectors in any cycle.
- DATA_MEM_CHANNELS=1: rr_ptr is constant 0. Cooldown forces at least one idle cycle between consecutive accesses (5-cycle period).

Test Plan:
- Reset check: hold rst_n=0 for 2 cycles with all valids high -> all outputs 0 and busy=0. After release, the first sram_en appears 2 cycles later, for channel 0.
- Single write then read: ch2 writes addr 0x15 data 0xA7 -> sram_en=1, we=1, addr=0x15, wdata=0xA7 in cycle k+1; write_ready[2] pulses in cycle k+3. Then ch2 reads 0x15 -> read_ready[2] pulses with read_data[2]=0xA7, 3 cycles after valid is sampled.
- Round-robin fairness: all 4 channels hold read_valid on addrs 0x10..0x13 (SRAM preloaded 0x10..0x13 -> 0x50..0x53) -> ready order ch0, ch1, ch2, ch3, 4 cycles apart. Each channel's data equals 0x50+ch.
- Same-channel read+write plus wrap-around: ch3 asserts write(0x20, 0x99) and read(0x20) simultaneously with rr_ptr=3 -> write served first. rr_ptr wraps to 0. The read, granted later, returns 0x99.
- Cooldown / lagging valid: ch1 keeps read_valid high 1 cycle after its ready pulse, with no other requests -> no second grant to ch1. The next sram_en occurs only if valid is still high 2 cycles after ACK.
- Reset mid-read: assert rst_n=0 during CAPTURE of a ch0 read -> no read_ready pulse, read_data[0]=0, FSM in IDLE. The request, re-presented after reset, completes normally.
